// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan readout path.
// Holds the readout FSM state encoding and the select-width helper that both
// channel_scan_reader and its mux parent use to size sel.
package scan_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StCsum = 2'd3
  } scan_state_e;

  // Width of a select able to address n channels (at least one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_scan_reader.sv
// channel_scan_reader: steps the channel mux select through all N channels,
// captures each WIDTH-bit result and emits it as a valid/ready word stream.
// Optional macro SCAN_CHECKSUM_EN appends an XOR checksum word to each frame.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle frame request, ignored while busy
//   sel        registered mux select
//   mux_data   mux output for the current sel
//   out_data   captured channel word (or checksum word)
//   out_chan   channel index of out_data
//   out_valid  word valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_last   final word of the frame
//   busy       frame in progress
//   done       one-cycle pulse after the final word is accepted
module channel_scan_reader
  import scan_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(N - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SCAN_CHECKSUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef SCAN_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = '0;
          busy_d  = 1'b1;
          state_d = StLoad;
`ifdef SCAN_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      // sel has been stable for a full cycle, so mux_data is settled.
      StLoad: begin
        out_data_d  = mux_data;
        out_chan_d  = sel_q;
        out_valid_d = 1'b1;
`ifdef SCAN_CHECKSUM_EN
        out_last_d  = 1'b0;
        acc_d       = acc_q ^ mux_data;
`else
        out_last_d  = (sel_q == LastSel);
`endif
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (sel_q != LastSel) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = StLoad;
          end else begin
`ifdef SCAN_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef SCAN_CHECKSUM_EN
      // First cycle presents the checksum, then wait for its handshake.
      StCsum: begin
        if (!out_valid_q) begin
          out_data_d  = acc_q;
          out_chan_d  = '0;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SCAN_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
